// File: rtl/bus_arb_pkg.sv
// Purpose: shared state encoding, sizing defaults and index helper for the bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int OWNER_W      = 2;
    localparam int MAX_HOLD_DEF = 8;

    // Next requester index in round-robin order, wrapping the last one back to 0.
    function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] idx, input int n);
        return (idx == OWNER_W'(n - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Purpose: round-robin search for the first set request at or above ptr (mod N_REQ).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the request vector and pointer.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [OWNER_W-1:0] ptr,
    output logic               found,
    output logic [OWNER_W-1:0] idx
);

    logic [OWNER_W-1:0] cand;

    // Walk offsets from the far end down so the smallest offset from ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = OWNER_W'((int'(ptr) + i) % N_REQ);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Purpose: round-robin bus arbiter with a guaranteed dead cycle between owners; optional forced release under BUS_ARB_TIMEOUT_EN.
// Latency: registered outputs, grant one edge after a request is seen in IDLE or TURNAROUND.
// Backpressure: level requests; an owner keeps the bus while its request stays high (or until forced off).
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               arb_clk,
    input  logic               arb_rst,
    input  logic [N_REQ-1:0]   arb_req,
    output logic [N_REQ-1:0]   arb_gnt,
    output logic [OWNER_W-1:0] arb_owner,
    output logic               arb_busy,
    output logic               arb_timeout
);

    arb_state_t         state_q;
    arb_state_t         state_nxt;
    logic [OWNER_W-1:0] rr_ptr;
    logic [OWNER_W-1:0] rr_ptr_nxt;
    logic [N_REQ-1:0]   gnt_nxt;
    logic [OWNER_W-1:0] owner_nxt;
    logic               pick_found;
    logic [OWNER_W-1:0] pick_idx;
    logic               owner_req;
    logic               release_now;
    logic               force_release;

    // A hold limit below one cycle is meaningless; stop elaboration rather than build it.
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("bus_arbiter: MAX_HOLD must be at least 1");
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req   = arb_req[arb_owner];
    assign release_now = (state_q == GRANT) && !owner_req;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              timeout_q;
    logic              others_pending;

    // Only a competing requester can push the owner off; a voluntary release always takes priority.
    assign others_pending = |(arb_req & ~arb_gnt);
    assign force_release  = (state_q == GRANT) && owner_req && others_pending &&
                            (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // Hold counter: cleared on grant entry, counts GRANT cycles, saturates at the limit.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if ((state_nxt == GRANT) && (state_q != GRANT)) begin
            hold_cnt_nxt = '0;
        end else if ((state_q == GRANT) && (hold_cnt != HOLD_W'(MAX_HOLD - 1))) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
        end
    end

    // Hold counter and one-cycle timeout pulse registers.
    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_nxt;
            timeout_q <= force_release;
        end
    end

    assign arb_timeout = timeout_q;
`else
    assign force_release = 1'b0;
    assign arb_timeout   = 1'b0;
`endif

    // State register plus the registered outputs and round-robin pointer.
    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            state_q   <= IDLE;
            arb_gnt   <= '0;
            arb_owner <= '0;
            arb_busy  <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            state_q   <= state_nxt;
            arb_gnt   <= gnt_nxt;
            arb_owner <= owner_nxt;
            arb_busy  <= |gnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
        end
    end

    // Next state: select from IDLE/TURNAROUND, leave GRANT on release or forced release.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE, TURNAROUND: state_nxt = pick_found ? GRANT : IDLE;
            GRANT: begin
                if (release_now || force_release) begin
                    state_nxt = TURNAROUND;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next outputs: load the picked owner, or drop the bus and advance the pointer past the owner.
    always_comb begin
        gnt_nxt    = arb_gnt;
        owner_nxt  = arb_owner;
        rr_ptr_nxt = rr_ptr;
        case (state_q)
            IDLE, TURNAROUND: begin
                gnt_nxt = '0;
                if (pick_found) begin
                    gnt_nxt   = {{(N_REQ - 1){1'b0}}, 1'b1} << pick_idx;
                    owner_nxt = pick_idx;
                end
            end
            GRANT: begin
                if (release_now || force_release) begin
                    gnt_nxt    = '0;
                    rr_ptr_nxt = wrap_inc(arb_owner, N_REQ);
                end
            end
            default: gnt_nxt = '0;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Purpose: directed self-checking bench for bus_arbiter with a per-edge expectation scoreboard.
// Latency: expectations are pushed with the stimulus and popped one edge later, sampled 1 ns after the edge.
// Backpressure: n/a; requester behaviour is scripted step by step.
module tb_bus_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       timeout;
    } exp_t;

    logic       arb_clk;
    logic       arb_rst;
    logic [3:0] arb_req;
    logic [3:0] arb_gnt;
    logic [1:0] arb_owner;
    logic       arb_busy;
    logic       arb_timeout;

    exp_t       sb_q[$];
    string      tag_q[$];
    logic [3:0] prev_gnt;
    int         n_cmp;
    int         n_fail;

    bus_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (8)
    ) dut (
        .arb_clk     (arb_clk),
        .arb_rst     (arb_rst),
        .arb_req     (arb_req),
        .arb_gnt     (arb_gnt),
        .arb_owner   (arb_owner),
        .arb_busy    (arb_busy),
        .arb_timeout (arb_timeout)
    );

    initial arb_clk = 1'b0;
    always #5 arb_clk = ~arb_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic compare_pop();
        exp_t  e;
        string t;
        n_cmp++;
        assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard: observed %0d pending entries required at least 1", sb_q.size());
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".gnt"},     arb_gnt,             e.gnt);
            chk({t, ".owner"},   {2'b00, arb_owner},  {2'b00, e.owner});
            chk({t, ".busy"},    {3'b000, arb_busy},  {3'b000, e.busy});
            chk({t, ".timeout"}, {3'b000, arb_timeout}, {3'b000, e.timeout});
            chk({t, ".onehot"},  {3'b000, ($countones(arb_gnt) <= 1)}, 4'h1);
            chk({t, ".no_adjacent_owner"},
                {3'b000, ((prev_gnt != 4'h0) && (arb_gnt != 4'h0) && (prev_gnt != arb_gnt))}, 4'h0);
            prev_gnt = arb_gnt;
        end
    endtask

    // Drive one cycle of stimulus, record what the edge must produce, then check it.
    task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] g,
                        input logic [1:0] o, input logic b, input logic t, input string tag);
        arb_rst = rst;
        arb_req = req;
        sb_q.push_back('{gnt: g, owner: o, busy: b, timeout: t});
        tag_q.push_back(tag);
        @(posedge arb_clk);
        #1;
        compare_pop();
    endtask

    initial begin
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        logic       t;
        n_cmp    = 0;
        n_fail   = 0;
        prev_gnt = 4'h0;
        arb_rst  = 1'b1;
        arb_req  = 4'h0;

        // Reset state, and requests present during reset are ignored.
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "reset");
        step(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, "req_in_reset");

        // Single request grants on the first edge after reset deasserts.
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "first_grant");
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "hold2");
        step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "release2");
        step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "idle_keeps_owner");

        // All four requesting from reset: round robin 0,1,2,3,0 with a dead cycle between owners.
        step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_reset");
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'b1111, 4'b0001 << k, 2'(k), 1'b1, 1'b0, $sformatf("rr_gnt%0d_a", k));
            step(1'b0, 4'b1111, 4'b0001 << k, 2'(k), 1'b1, 1'b0, $sformatf("rr_gnt%0d_b", k));
            step(1'b0, 4'b1111 & ~(4'b0001 << k), 4'b0000, 2'(k), 1'b0, 1'b0, $sformatf("rr_dead%0d", k));
        end
        step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_wrap_gnt0");
        step(1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_wrap_dead");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_idle");

        // Owner 1 holds with requester 0 also pending for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            g = 4'b0010; o = 2'd1; b = 1'b1; t = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            if (i == 8) begin
                g = 4'b0000; o = 2'd1; b = 1'b0; t = 1'b1;
            end else if (i >= 9 && i <= 16) begin
                g = 4'b0001; o = 2'd0; b = 1'b1; t = 1'b0;
            end else if (i == 17) begin
                g = 4'b0000; o = 2'd0; b = 1'b0; t = 1'b1;
            end
`endif
            step(1'b0, 4'b0011, g, o, b, t, $sformatf("hold1_c%0d", i));
        end
        step(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "hold1_release");
        step(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "hold1_idle");

        // Owner 3 alone for 20 cycles: never forced off; release wraps the pointer to 0.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, $sformatf("alone3_c%0d", i));
        end
        step(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "alone3_release");
        step(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "alone3_idle");
        step(1'b0, 4'b1011, 4'b0001, 2'd0, 1'b1, 1'b0, "ptr_wrapped_to0");

        // Owner 0 releases on the very edge its hold limit would force it off.
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 4'b1011, 4'b0001, 2'd0, 1'b1, 1'b0, $sformatf("edge_hold_c%0d", i));
        end
        step(1'b0, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0, "release_beats_timeout");
        step(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, "after_release_gnt1");

        // Reset pulsed mid-grant drops the bus at once and the request is regranted afterwards.
        step(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "pre_rst_release");
        step(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "pre_rst_idle");
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "pre_rst_gnt2");
        step(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, "mid_grant_reset");
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "regrant_after_rst");
        step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "post_rst_release");
        step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "post_rst_idle");

        // A request pulse that lives entirely between edges is never seen.
        sb_q.push_back('{gnt: 4'b0000, owner: 2'd2, busy: 1'b0, timeout: 1'b0});
        tag_q.push_back("glitch_ignored");
        arb_req = 4'b0001;
        #3;
        arb_req = 4'b0000;
        @(posedge arb_clk);
        #1;
        compare_pop();
        step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "level_req_after_glitch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be `N_REQ`, default 4, number of bus requesters; and `MAX_HOLD`, default 8, maximum grant cycles before forced release.
REQ-002 Ports SHALL be exactly as follows:
- `arb_clk`  input  1  clock; all state changes on the rising edge
- `arb_rst`  input  1  reset, synchronous, active-high
- `arb_req`  input  N_REQ  level requests; bit 0 = A reg buffer, 1 = ALU buffer, 2 = memory buffer, 3 = external
- `arb_gnt`  output  N_REQ  one-hot/zero grant; drives the bus tri-state enables
- `arb_owner`  output  2  index of the current grantee; holds the last owner when idle
- `arb_busy`  output  1  high while any grant bit is high
- `arb_timeout`  output  1  one-cycle pulse on forced release

Function
REQ-003 The FSM SHALL have three states: IDLE, GRANT and TURNAROUND.
REQ-004 All outputs SHALL be registered; request-to-grant latency SHALL be 1 edge from IDLE.
REQ-005 In IDLE, if any `arb_req` bit is high, the arbiter SHALL pick the first set bit searching from `rr_ptr` upward (mod N_REQ), set that grant bit, load `arb_owner`, and go to GRANT.
- If no request is high, it SHALL stay in IDLE.
REQ-006 In GRANT, the grant SHALL be held while `arb_req[arb_owner]` is 1.
- At the first edge where it samples 0: gnt goes to 0, state goes to TURNAROUND, and `rr_ptr` becomes owner+1 (mod N_REQ, wraps 3 to 0).
REQ-007 TURNAROUND SHALL last exactly one cycle with `arb_gnt` = 0, guaranteeing a dead bus cycle between owners.
- It SHALL then apply the IDLE selection rule: go to GRANT with the new owner, or to IDLE.
REQ-008 `arb_gnt` SHALL never have more than one bit set; two consecutive different owners SHALL never be granted on adjacent cycles.
REQ-009 A request raised and dropped between edges SHALL be ignored; requests are level-sampled only at edges.
REQ-010 A request raised in the same cycle the owner releases SHALL be eligible at the TURNAROUND evaluation.
REQ-011 The `hold_cnt` register SHALL be 0 on grant entry, increment each GRANT cycle, and saturate at MAX_HOLD-1.
REQ-012 When `hold_cnt` = MAX_HOLD-1, the owner still requests, and another request is pending, the arbiter SHALL do all of the following at the next edge:
- gnt goes to 0
- state goes to TURNAROUND
- `arb_timeout` = 1 for one cycle
- `rr_ptr` = owner+1
REQ-013 With no other request pending, the owner SHALL keep the grant indefinitely and no timeout SHALL fire.
REQ-014 If the owner releases on the same edge a timeout would fire, it SHALL be a normal release with `arb_timeout` = 0.

Reset
REQ-015 On an `arb_rst`-sampled edge, the arbiter SHALL set:
- state = IDLE
- `arb_gnt` = 0
- `arb_owner` = 0
- `arb_busy` = 0
- `arb_timeout` = 0
- `rr_ptr` = 0
- `hold_cnt` = 0
REQ-016 Reset mid-grant SHALL drop the grant on that edge; no TURNAROUND and no timeout pulse SHALL occur.
REQ-017 Requests sampled during reset SHALL be ignored; the first grant is possible at the edge after reset deasserts.

Configuration
REQ-018 Macro `BUS_ARB_TIMEOUT_EN` SHALL control forced release.
- Defined: REQ-011..REQ-014 apply.
- Undefined: `hold_cnt` logic is absent, an owner holds until it releases, and `arb_timeout` is tied to 0.

Structure
REQ-019 Package `bus_arb_pkg` SHALL hold:
- the state encoding (IDLE, GRANT, TURNAROUND)
- the `N_REQ` default
- the owner-index width
- the `MAX_HOLD` default
REQ-020 Combinational sub-module `rr_pick` SHALL take the request vector and `rr_ptr` and return a found flag and the selected index; it is instantiated once.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then `arb_req` = 0100 → gnt = 0100 one edge later, owner = 2, busy = 1.
- `arb_req` = 1111 from reset, each owner releasing after 2 cycles → grant order 0,1,2,3,0, with exactly one zero-gnt cycle between owners.
- Owner 1 holds, `arb_req` = 0011 for 20 cycles, MAX_HOLD = 8, macro defined → gnt 0010 for 8 cycles, then 0000 with timeout = 1, then 0001. Macro undefined → gnt stays 0010 for all 20 cycles.
- Owner 3 holds alone for 20 cycles, macro defined → no timeout; on release → `rr_ptr` wraps to 0.
- `arb_rst` pulsed while gnt = 0100 → gnt = 0000 and owner = 0 next edge, no timeout; the pending request is regranted one edge after reset deasserts.
- Owner release and timeout on the same edge → `arb_timeout` stays 0.
